// File: rtl/rv_pkg.sv
// ============================================================================
// Module      : rv_pkg
// Description : Shared load/store encodings and LSU state type for the MEM stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package rv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // funct3[1:0] alone carries the access size for loads and stores
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// Module      : load_align
// Description : Selects the addressed byte/half of a read word and extends it.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module load_align
    import rv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[{byte_off, 3'b000} +: 8];
        w_half = byte_off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   data = {24'h0, w_byte};
            F3_H:    data = {{16{w_half[15]}}, w_half};
            F3_HU:   data = {16'h0, w_half};
            default: data = rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage_lsu.sv
// ============================================================================
// Module      : mem_stage_lsu
// Description : MEM-stage load/store unit with a single outstanding request,
//               misalignment detection and bus-timeout error reporting.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_stage_lsu
    import rv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic [31:0] mem_data_out,
    output logic        misalign_out,
    output logic        bus_err_out
);

    localparam logic [7:0] C_LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_t  r_state;
    lsu_state_t  w_next;
    logic [7:0]  r_cnt;
    logic        r_is_load;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic        w_access_start;
    logic        w_misaligned;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;

    assign w_access_start = valid_in & (mem_read_in | mem_write_in) & (r_state == ST_IDLE);
    assign w_timeout      = (r_cnt == C_LAST_WAIT);
    assign dmem_req       = (r_state == ST_BUSY);
    // rst gate keeps stall low during reset even if EX/MEM still shows a load/store
    assign stall_out      = ~rst & (w_access_start | (r_state == ST_BUSY));

    always_comb begin
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wdata      = store_data_in;
        case (funct3_in[1:0])
            SZ_BYTE: begin
                w_be    = 4'b0001 << alu_result_in[1:0];
                w_wdata = {4{store_data_in[7:0]}};
            end
            SZ_HALF: begin
                w_misaligned = alu_result_in[0];
                w_be         = 4'b0011 << alu_result_in[1:0];
                w_wdata      = {2{store_data_in[15:0]}};
            end
            default: begin
                w_misaligned = |alu_result_in[1:0];
            end
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_access_start) begin
                    w_next = w_misaligned ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (dmem_ack || w_timeout) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    load_align u_load_align (
        .funct3   (r_funct3),
        .byte_off (r_off),
        .rdata    (dmem_rdata),
        .data     (w_load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 8'd0;
            r_is_load    <= 1'b0;
            r_funct3     <= 3'b000;
            r_off        <= 2'b00;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'h0;
            dmem_be      <= 4'h0;
            dmem_wdata   <= 32'h0;
            mem_data_out <= 32'h0;
            misalign_out <= 1'b0;
            bus_err_out  <= 1'b0;
        end else begin
            r_state      <= w_next;
            misalign_out <= 1'b0;
            bus_err_out  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_access_start) begin
                        r_cnt     <= 8'd0;
                        r_is_load <= ~mem_write_in;
                        r_funct3  <= funct3_in;
                        r_off     <= alu_result_in[1:0];
                        if (w_misaligned) begin
                            misalign_out <= 1'b1;
                        end else begin
                            dmem_we    <= mem_write_in;
                            dmem_addr  <= {alu_result_in[31:2], 2'b00};
                            dmem_be    <= w_be;
                            dmem_wdata <= w_wdata;
                        end
                    end
                end
                ST_BUSY: begin
                    // ack takes priority over a timeout landing on the same cycle
                    if (dmem_ack) begin
                        if (r_is_load) begin
                            mem_data_out <= w_load_data;
                        end
                    end else if (w_timeout) begin
                        bus_err_out <= 1'b1;
                        if (r_is_load) begin
                            mem_data_out <= 32'h0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Self-checking bench: directed vector table, reset corner cases
//               and randomized accesses against a behavioural model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage_lsu;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, mem_read_in, mem_write_in;
    logic [2:0]  funct3_in;
    logic [31:0] alu_result_in, store_data_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall_out;
    logic [31:0] mem_data_out;
    logic        misalign_out, bus_err_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model_data = 32'h0;

    mem_stage_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .funct3_in(funct3_in), .alu_result_in(alu_result_in),
        .store_data_in(store_data_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_out(stall_out),
        .mem_data_out(mem_data_out), .misalign_out(misalign_out), .bus_err_out(bus_err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rd; logic wr; logic [2:0] f3; logic [31:0] addr; logic [31:0] sdata;
        logic [31:0] rdata; int ack_at;
        logic [31:0] e_addr; logic [3:0] e_be; logic [31:0] e_wdata; logic [31:0] e_data;
        int e_req; int e_stall; logic e_mis; logic e_err;
    } vec_t;

    typedef struct {
        int completed; int req_cycles; int stall_cycles; int spurious; int stable;
        logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata;
        logic mis; logic err; logic [31:0] data; logic done_stall; logic after_ok;
    } obs_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issues one access, acts as the memory (ack on BUSY cycle ack_at, 0 = never)
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd,
                              input logic [31:0] rdat, input int ack_at, output obs_t o);
        int busy = 0;
        o = '{default: 0};
        o.stable = 1;
        @(posedge clk); #1;
        valid_in = 1'b1; mem_read_in = rd; mem_write_in = wr; funct3_in = f3;
        alu_result_in = a; store_data_in = sd; dmem_ack = 1'b0;
        @(negedge clk);
        o.stall_cycles += int'(stall_out);
        o.spurious += int'(misalign_out | bus_err_out | dmem_req);
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (dmem_req) begin
                busy++;
                dmem_ack   = (busy == ack_at);
                dmem_rdata = dmem_ack ? rdat : $urandom;
                @(negedge clk);
                o.req_cycles++;
                o.stall_cycles += int'(stall_out);
                o.spurious += int'(misalign_out | bus_err_out);
                if (busy == 1) begin
                    o.addr = dmem_addr; o.be = dmem_be; o.we = dmem_we; o.wdata = dmem_wdata;
                end else if (dmem_addr !== o.addr || dmem_be !== o.be ||
                             dmem_we !== o.we || dmem_wdata !== o.wdata) begin
                    o.stable = 0;
                end
            end else begin
                dmem_ack = 1'b0;
                @(negedge clk);
                o.done_stall = stall_out;
                o.stall_cycles += int'(stall_out);
                o.mis = misalign_out; o.err = bus_err_out; o.data = mem_data_out;
                o.completed = 1;
                break;
            end
        end
        @(posedge clk); #1;
        valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0; dmem_ack = 1'b0;
        @(negedge clk);
        o.after_ok = !dmem_req && !stall_out && !misalign_out && !bus_err_out;
    endtask

    task automatic compare(input string tag, input obs_t o, input int e_req, input int e_stall,
                           input logic e_mis, input logic e_err, input logic [31:0] e_data,
                           input logic [31:0] e_addr, input logic [3:0] e_be, input logic e_we,
                           input logic [31:0] e_wdata);
        check({tag, " completed"}, o.completed, 1);
        check({tag, " req_cycles"}, o.req_cycles, e_req);
        check({tag, " stall_cycles"}, o.stall_cycles, e_stall);
        check({tag, " misalign"}, {31'h0, o.mis}, {31'h0, e_mis});
        check({tag, " bus_err"}, {31'h0, o.err}, {31'h0, e_err});
        check({tag, " mem_data_out"}, o.data, e_data);
        check({tag, " pulse_outside_done"}, o.spurious, 0);
        check({tag, " idle_after"}, {31'h0, o.after_ok}, 32'h1);
        if (e_req > 0) begin
            check({tag, " bus_stable"}, o.stable, 1);
            check({tag, " dmem_addr"}, o.addr, e_addr);
            check({tag, " dmem_be"}, {28'h0, o.be}, {28'h0, e_be});
            check({tag, " dmem_we"}, {31'h0, o.we}, {31'h0, e_we});
            if (e_we) check({tag, " dmem_wdata"}, o.wdata, e_wdata);
        end
    endtask

    // Reference model: extracts the addressed field arithmetically from the word
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        longint v;
        case (f3[1:0])
            2'b00: begin
                v = (longint'(w) >> (8 * a[1:0])) % 256;
                if (!f3[2] && v >= 128) v -= 256;
            end
            2'b01: begin
                v = (longint'(w) >> (16 * a[1])) % 65536;
                if (!f3[2] && v >= 32768) v -= 65536;
            end
            default: v = longint'(w);
        endcase
        return 32'(v);
    endfunction

    vec_t vecs[$];
    obs_t o;

    initial begin
        rst = 1'b1; valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0;
        funct3_in = 3'b010; alu_result_in = 32'h100; store_data_in = 32'h0;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        #12;
        check("reset dmem_req", {31'h0, dmem_req}, 0);
        check("reset stall_out", {31'h0, stall_out}, 0);
        check("reset bus fields", {dmem_we, dmem_be, 27'h0} | dmem_addr | dmem_wdata, 0);
        check("reset mem_data_out", mem_data_out, 0);
        check("reset pulses", {30'h0, misalign_out, bus_err_out}, 0);
        valid_in = 1'b0; mem_read_in = 1'b0;
        @(negedge clk); rst = 1'b0;

        //          rd  wr  f3      addr          sdata         rdata         ack  e_addr        be      e_wdata       e_data        req sta mis err
        vecs.push_back('{1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1,  32'h100, 4'b1111, 32'h0,        32'hDEADBEEF, 1,  2,  0, 0});
        vecs.push_back('{1, 0, 3'b000, 32'h103, 32'h0,        32'h80FFFFFF, 1,  32'h100, 4'b1000, 32'h0,        32'hFFFFFF80, 1,  2,  0, 0});
        vecs.push_back('{1, 0, 3'b100, 32'h103, 32'h0,        32'h80FFFFFF, 1,  32'h100, 4'b1000, 32'h0,        32'h00000080, 1,  2,  0, 0});
        vecs.push_back('{0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h55555555, 1,  32'h100, 4'b1100, 32'hABCDABCD, 32'h00000080, 1,  2,  0, 0});
        vecs.push_back('{1, 0, 3'b010, 32'h101, 32'h0,        32'h0,        1,  32'h0,   4'b0000, 32'h0,        32'h00000080, 0,  1,  1, 0});
        vecs.push_back('{1, 0, 3'b010, 32'h200, 32'h0,        32'h0,        0,  32'h200, 4'b1111, 32'h0,        32'h00000000, 16, 17, 0, 1});
        vecs.push_back('{1, 0, 3'b010, 32'h204, 32'h0,        32'h11223344, 16, 32'h204, 4'b1111, 32'h0,        32'h11223344, 16, 17, 0, 0});
        vecs.push_back('{1, 0, 3'b001, 32'h102, 32'h0,        32'h80010000, 3,  32'h100, 4'b1100, 32'h0,        32'hFFFF8001, 3,  4,  0, 0});
        vecs.push_back('{1, 0, 3'b101, 32'h106, 32'h0,        32'h80010000, 2,  32'h104, 4'b1100, 32'h0,        32'h00008001, 2,  3,  0, 0});
        vecs.push_back('{0, 1, 3'b000, 32'h101, 32'h000000A5, 32'h0,        1,  32'h100, 4'b0010, 32'hA5A5A5A5, 32'h00008001, 1,  2,  0, 0});
        vecs.push_back('{0, 1, 3'b010, 32'h10C, 32'hCAFEF00D, 32'h0,        4,  32'h10C, 4'b1111, 32'hCAFEF00D, 32'h00008001, 4,  5,  0, 0});
        vecs.push_back('{1, 0, 3'b001, 32'h101, 32'h0,        32'h0,        1,  32'h0,   4'b0000, 32'h0,        32'h00008001, 0,  1,  1, 0});
        vecs.push_back('{1, 0, 3'b000, 32'h100, 32'h0,        32'h1234567F, 1,  32'h100, 4'b0001, 32'h0,        32'h0000007F, 1,  2,  0, 0});
        vecs.push_back('{0, 1, 3'b001, 32'h203, 32'hFFFF0000, 32'h0,        1,  32'h0,   4'b0000, 32'h0,        32'h0000007F, 0,  1,  1, 0});

        foreach (vecs[i]) begin
            run_access(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].sdata,
                       vecs[i].rdata, vecs[i].ack_at, o);
            compare($sformatf("vec%0d", i), o, vecs[i].e_req, vecs[i].e_stall, vecs[i].e_mis,
                    vecs[i].e_err, vecs[i].e_data, vecs[i].e_addr, vecs[i].e_be, vecs[i].wr,
                    vecs[i].e_wdata);
        end
        model_data = 32'h0000007F;

        // Non-memory slot and empty slot: no stall, no request, data held
        begin
            int seen = 0;
            @(posedge clk); #1;
            valid_in = 1'b1; mem_read_in = 1'b0; mem_write_in = 1'b0; alu_result_in = 32'h100;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                seen += int'(stall_out | dmem_req);
            end
            valid_in = 1'b0; mem_read_in = 1'b1;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                seen += int'(stall_out | dmem_req);
            end
            mem_read_in = 1'b0;
            check("nonmem no stall/req", seen, 0);
            check("nonmem mem_data_out held", mem_data_out, model_data);
        end

        // Reset in the middle of BUSY
        begin
            int busy = 0;
            int reissue = 0;
            @(posedge clk); #1;
            valid_in = 1'b1; mem_read_in = 1'b1; funct3_in = 3'b010; alu_result_in = 32'h300;
            dmem_ack = 1'b0;
            for (int c = 0; c < 10 && busy < 3; c++) begin
                @(posedge clk); #1;
                if (dmem_req) busy++;
            end
            check("rstbusy reached 3rd BUSY", busy, 3);
            check("rstbusy req before rst", {31'h0, dmem_req}, 1);
            #2 rst = 1'b1;
            #1;
            check("rstbusy req drops async", {31'h0, dmem_req}, 0);
            check("rstbusy stall drops async", {31'h0, stall_out}, 0);
            check("rstbusy mem_data_out cleared", mem_data_out, 0);
            valid_in = 1'b0; mem_read_in = 1'b0;
            @(negedge clk); rst = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                reissue += int'(dmem_req | stall_out);
            end
            check("rstbusy no reissue", reissue, 0);
            model_data = 32'h0;
        end

        // Randomized accesses against the behavioural model
        for (int n = 0; n < 40; n++) begin
            logic        is_ld, mis, ack_ok;
            logic [2:0]  f3;
            logic [31:0] a, sd, rd_w, e_data;
            int          ack_at, sel, e_req;
            logic [3:0]  e_be;
            logic [31:0] e_wd;
            is_ld = $urandom_range(0, 1) == 1;
            sel   = $urandom_range(0, is_ld ? 4 : 2);
            f3    = (sel == 0) ? 3'b000 : (sel == 1) ? 3'b001 : (sel == 2) ? 3'b010 :
                    (sel == 3) ? 3'b100 : 3'b101;
            a     = $urandom;
            sd    = $urandom;
            rd_w  = $urandom;
            case ($urandom_range(0, 9))
                0:       ack_at = 0;
                1:       ack_at = TMO;
                2:       ack_at = TMO + 1;
                default: ack_at = $urandom_range(1, 5);
            endcase
            mis    = (f3[1:0] == 2'b01 && a % 2 != 0) || (f3[1:0] == 2'b10 && a % 4 != 0);
            ack_ok = ack_at >= 1 && ack_at <= TMO;
            e_req  = mis ? 0 : (ack_ok ? ack_at : TMO);
            case (f3[1:0])
                2'b00: begin e_be = 4'(1 << (a % 4)); e_wd = sd[7:0] * 32'h01010101; end
                2'b01: begin e_be = 4'(3 << (a % 4)); e_wd = sd[15:0] * 32'h00010001; end
                default: begin e_be = 4'hF; e_wd = sd; end
            endcase
            e_data = model_data;
            if (is_ld && !mis) e_data = ack_ok ? model_load(f3, a, rd_w) : 32'h0;
            run_access(is_ld, !is_ld, f3, a, sd, rd_w, ack_at, o);
            compare($sformatf("rand%0d", n), o, e_req, mis ? 1 : e_req + 1, mis,
                    !mis && !ack_ok, e_data, {a[31:2], 2'b00}, e_be, !is_ld, e_wd);
            model_data = e_data;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 Parameter SHALL be TIMEOUT_CYCLES, default 16, the number of BUSY cycles without dmem_ack before a bus error is declared (legal range 1-255).
REQ-002 SHALL have one clock and an asynchronous, active-high reset, with the following ports (clock and reset first):
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- valid_in  in  1  EX/MEM slot holds a live instruction.
- mem_read_in  in  1  instruction is a load.
- mem_write_in  in  1  instruction is a store.
- funct3_in  in  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010.
- alu_result_in  in  32  effective byte address.
- store_data_in  in  32  rs2 value, unaligned.
- dmem_req  out  1  data-memory request, held until ack.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address, bits[1:0] = 0.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_ack  in  1  memory completes the held request this cycle.
- dmem_rdata  in  32  read word, valid with dmem_ack.
- stall_out  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; insert bubble into MEM/WB.
- mem_data_out  out  32  aligned, extended load result into MEM/WB mem_data_in.
- misalign_out  out  1  one-cycle pulse: misaligned access, no bus request made.
- bus_err_out  out  1  one-cycle pulse: access timed out.

Function
REQ-003 The block SHALL use the states IDLE, BUSY and DONE.
REQ-004 access_start SHALL equal valid_in & (mem_read_in | mem_write_in) & state==IDLE.
REQ-005 Misalignment SHALL be defined as a halfword access with addr[0]=1 or a word access with addr[1:0]!=0.
REQ-006 On an aligned access_start, the block SHALL register the address, we, be and wdata and SHALL go IDLE->BUSY.
REQ-007 On a misaligned access_start, the block SHALL go IDLE->DONE with misalign flagged and SHALL NOT assert dmem_req.
REQ-008 dmem_req SHALL equal state==BUSY, and all dmem_* outputs SHALL stay stable throughout BUSY.
REQ-009 In BUSY with dmem_ack=1, the block SHALL capture the formatted load data into mem_data_out and go to DONE.
REQ-010 In BUSY, a timeout counter SHALL increment each cycle without ack; reaching TIMEOUT_CYCLES SHALL force DONE with bus_err flagged and mem_data_out = 0.
REQ-011 If dmem_ack arrives on the same cycle the counter reaches TIMEOUT_CYCLES, ack SHALL win and no error is raised.
REQ-012 DONE->IDLE SHALL be unconditional, and access_start SHALL be ignored in DONE.
REQ-013 stall_out SHALL equal access_start | state==BUSY, and SHALL be 0 in DONE.
REQ-014 Minimum latency SHALL be: start cycle, one BUSY cycle with ack, then DONE; stall_out is high for 2 cycles.
REQ-015 misalign_out and bus_err_out SHALL be asserted only during DONE.
REQ-016 Store lanes SHALL be: SB be=0001<<addr[1:0] with the byte replicated ×4; SH be=0011<<addr[1:0] with the half replicated ×2; SW be=1111.
REQ-017 Load formatting SHALL select the byte or half by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-018 Stores SHALL leave mem_data_out unchanged.
REQ-019 Non-memory instructions and valid_in=0 SHALL cause no request and no stall, and SHALL leave mem_data_out unchanged.
REQ-020 The block SHALL present at most one outstanding request at any time.

Reset
REQ-021 While rst=1, the block SHALL hold state=IDLE, timeout counter 0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, mem_data_out=0, stall_out=0, misalign_out=0 and bus_err_out=0, asynchronously.
REQ-022 Reset asserted mid-BUSY SHALL drop dmem_req immediately, and the abandoned access SHALL NOT be reissued.

Structure
REQ-023 Package rv_pkg SHALL hold the funct3 load/store encodings, the lsu_state_t enum and the default TIMEOUT_CYCLES.
REQ-024 A single combinational sub-module, load_align, SHALL implement REQ-017 and SHALL be instantiated once.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- LW addr 0x100, ack on the first BUSY cycle, rdata 0xDEADBEEF -> dmem_addr 0x100, be 1111, stall high 2 cycles, mem_data_out 0xDEADBEEF in DONE.
- LB addr 0x103, rdata 0x80FF_FFFF -> mem_data_out 0xFFFFFF80; same access as LBU -> 0x00000080.
- SH addr 0x102, data 0x1234ABCD -> be 1100, wdata 0xABCDABCD, we=1, mem_data_out unchanged.
- LW addr 0x101 -> misalign_out pulses in DONE, dmem_req never asserted, stall high 1 cycle.
- LW with ack withheld -> dmem_req high exactly 16 cycles, then bus_err_out pulse and mem_data_out 0; repeat with ack on cycle 16 -> no error.
- rst raised on the 3rd BUSY cycle -> dmem_req and stall_out go 0 without a clock edge; after release, state is IDLE and no request is issued.
